// File: rtl/id_hazard_ctrl_if.sv
// IO request/acknowledge handshake between the ID-stage sequencer and the IO device.
// The sequencer is the master and raises io_req. The device is the slave and pulses io_ack.
interface id_hazard_ctrl_if;
  logic io_req;
  logic io_ack;

  modport master (output io_req, input io_ack);
  modport slave  (input io_req, output io_ack);
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage sequencer. It detects load-use and branch-operand hazards and selects
// branch-comparator forwarding. It holds IO loads/stores in ID until the device acks.
module id_hazard_ctrl #(
  parameter int IO_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_io_inst,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       mem_wreg,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_wreg,
  id_hazard_ctrl_if.master io,
  output logic             pipe_stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             io_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int              TO_W   = $clog2(IO_TIMEOUT);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_IO_WAIT, ST_IO_DONE} state_e;

  state_e           state_q, state_d;
  logic             io_req_q, io_req_d;
  logic             io_err_q, io_err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic ex_any, mem_any, data_hazard;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic src_match(input logic we, input logic [4:0] wreg,
                                     input logic [4:0] src);
    return we && (wreg != 5'd0) && (wreg == src);
  endfunction

  assign ex_rs   = src_match(ex_regwrite, ex_wreg, id_rs);
  assign ex_rt   = id_uses_rt && src_match(ex_regwrite, ex_wreg, id_rt);
  assign mem_rs  = src_match(mem_regwrite, mem_wreg, id_rs);
  assign mem_rt  = id_uses_rt && src_match(mem_regwrite, mem_wreg, id_rt);
  assign wb_rs   = src_match(wb_regwrite, wb_wreg, id_rs);
  assign wb_rt   = id_uses_rt && src_match(wb_regwrite, wb_wreg, id_rt);
  assign ex_any  = ex_rs || ex_rt;
  assign mem_any = mem_rs || mem_rt;

  // The branch comparator sits in ID, so any EX producer and any MEM load are still too late.
  assign data_hazard = rst_n && ((ex_memread && ex_any) ||
                                 (id_branch && ex_any) ||
                                 (id_branch && mem_memread && mem_any));

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst_n) begin
      if (mem_rs && !mem_memread) fwd_a = 2'b10;
      else if (wb_rs)             fwd_a = 2'b01;
      if (mem_rt && !mem_memread) fwd_b = 2'b10;
      else if (wb_rt)             fwd_b = 2'b01;
    end
  end

  // NOTE: every signal written in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    io_err_d    = io_err_q;
    to_cnt_d    = to_cnt_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      ST_RUN: begin
        if (!data_hazard && id_io_inst) begin
          state_d  = ST_IO_WAIT;
          to_cnt_d = '0;
        end
      end
      ST_IO_WAIT: begin
        if (io.io_ack) begin
          state_d = ST_IO_DONE;
        end else if (to_cnt_q == TO_MAX) begin
          state_d  = ST_IO_DONE;
          io_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_IO_DONE: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase

    io_req_d = (state_d == ST_IO_WAIT);

    pipe_stall = rst_n && (data_hazard || (state_q == ST_IO_WAIT) ||
                           ((state_q == ST_RUN) && id_io_inst));

    if (pipe_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      io_req_q    <= 1'b0;
      io_err_q    <= 1'b0;
      to_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      io_req_q    <= io_req_d;
      io_err_q    <= io_err_d;
      to_cnt_q    <= to_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_hold      = pipe_stall;
  assign ifid_hold    = pipe_stall;
  assign io.io_req    = io_req_q;
  assign io_err       = io_err_q;
  assign stall_cycles = stall_cnt_q;

endmodule
